// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared states and address constants for the MIPS instruction/data memory responders
package mips_mem_pkg;
  typedef enum logic {MEM_LOAD, MEM_SERVE} mem_state_t;
  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
  localparam logic [31:0] HALT_ADDR = 32'h00000000;
  localparam logic [31:0] NOP_WORD = 32'h00000000;
endpackage

// File: rtl/instr_addr_decode.sv
// instr_addr_decode: maps a CPU fetch byte address onto the instruction array
module instr_addr_decode
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter logic [31:0] BASE_ADDR = RESET_VECTOR,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic [31:0]   addr,
  output logic [AW-1:0] idx,
  output logic          aligned,
  output logic          in_range,
  output logic          halt
);
  logic [31:0] off;
  always_comb begin
    off = addr - BASE_ADDR;
    idx = off[AW+1:2];
    aligned = off[1:0] == 2'b00;
    in_range = off < 32'(DEPTH * 4);
    halt = addr == HALT_ADDR;
  end
endmodule

// File: rtl/mips_cpu_instr_memory.sv
// mips_cpu_instr_memory: stream-loaded instruction array answering CPU fetches at the reset vector
module mips_cpu_instr_memory
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter logic [31:0] BASE_ADDR = RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic        load_last,
  input  logic        reload,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  output logic        mem_ready,
  output logic        halted,
  output logic        fetch_fault,
  output logic        fault_seen,
  output logic        load_overflow,
  output logic [31:0] fetch_count
);
  localparam int AW = $clog2(DEPTH);
  mem_state_t state, state_next;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] ptr, wptr, idx;
  logic aligned, in_range, halt, serve, xfer, hit, wrap;
  instr_addr_decode #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) u_dec (
    .addr(instr_address),
    .idx(idx),
    .aligned(aligned),
    .in_range(in_range),
    .halt(halt)
  );
  always_comb begin
    serve = state == MEM_SERVE;
    load_ready = !serve;
    mem_ready = serve;
    xfer = load_valid && !serve;
    wptr = reload ? '0 : ptr;
    wrap = wptr == AW'(DEPTH - 1);
    hit = serve && aligned && in_range;
    instr_readdata = hit ? mem[idx] : NOP_WORD;
    fetch_fault = serve && !hit && !halt;
    state_next = serve ? (reload ? MEM_LOAD : MEM_SERVE)
                       : (xfer && (load_last || wrap) ? MEM_SERVE : MEM_LOAD);
  end
  always_ff @(posedge clk) state <= reset ? MEM_LOAD : state_next;
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      halted <= 1'b0;
      fault_seen <= 1'b0;
      load_overflow <= 1'b0;
      fetch_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= NOP_WORD;
    end else if (serve) begin
      if (reload) begin
        ptr <= '0;
        halted <= 1'b0;
        fault_seen <= 1'b0;
        fetch_count <= '0;
      end else begin
        if (halt) halted <= 1'b1;
        if (fetch_fault) fault_seen <= 1'b1;
        if (clk_enable && !halt && fetch_count != '1) fetch_count <= fetch_count + 32'd1;
      end
    end else begin
      ptr <= xfer ? wptr + AW'(1) : wptr;
      if (xfer) mem[wptr] <= load_data;
      if (xfer && !load_last && wrap) load_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mips_cpu_instr_memory.sv
// tb_mips_cpu_instr_memory: directed load/fetch stimulus with a queue-based scoreboard monitor
module tb_mips_cpu_instr_memory;
  logic clk = 0, reset = 1, clk_enable = 0, load_valid = 0, load_last = 0, reload = 0;
  logic [31:0] load_data = 0, instr_address = 0;
  logic load_ready, mem_ready, halted, fetch_fault, fault_seen, load_overflow;
  logic [31:0] instr_readdata, fetch_count;
  logic b_load_valid = 0;
  logic [31:0] b_load_data = 0, b_instr_address = 32'hBFC00000;
  logic b_load_ready, b_mem_ready, b_halted, b_fetch_fault, b_fault_seen, b_load_overflow;
  logic [31:0] b_instr_readdata, b_fetch_count;
  typedef struct { string name; int sig; logic [31:0] exp; } chk_t;
  chk_t q[$];
  int errors = 0, checks = 0;
  logic [31:0] prog [8] = '{32'h24210001, 32'h00010823, 32'h04300002, 32'h24420001,
                            32'h24420001, 32'h24420001, 32'h00000008, 32'h24000000};
  always #5 clk = ~clk;
  mips_cpu_instr_memory #(.DEPTH(64)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .load_valid(load_valid),
    .load_ready(load_ready), .load_data(load_data), .load_last(load_last), .reload(reload),
    .instr_address(instr_address), .instr_readdata(instr_readdata), .mem_ready(mem_ready),
    .halted(halted), .fetch_fault(fetch_fault), .fault_seen(fault_seen),
    .load_overflow(load_overflow), .fetch_count(fetch_count)
  );
  mips_cpu_instr_memory #(.DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .clk_enable(1'b0), .load_valid(b_load_valid),
    .load_ready(b_load_ready), .load_data(b_load_data), .load_last(1'b0), .reload(1'b0),
    .instr_address(b_instr_address), .instr_readdata(b_instr_readdata), .mem_ready(b_mem_ready),
    .halted(b_halted), .fetch_fault(b_fetch_fault), .fault_seen(b_fault_seen),
    .load_overflow(b_load_overflow), .fetch_count(b_fetch_count)
  );
  function automatic logic [31:0] actual(int s);
    case (s)
      0: return instr_readdata;
      1: return 32'(fetch_fault);
      2: return 32'(mem_ready);
      3: return 32'(load_ready);
      4: return 32'(halted);
      5: return 32'(fault_seen);
      6: return 32'(load_overflow);
      7: return fetch_count;
      8: return 32'(b_mem_ready);
      9: return 32'(b_load_overflow);
      10: return 32'(b_load_ready);
      default: return b_instr_readdata;
    endcase
  endfunction
  always @(negedge clk) begin
    while (q.size() > 0) begin
      chk_t e;
      logic [31:0] a;
      e = q.pop_front();
      a = actual(e.sig);
      checks++;
      if (a !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h at %0t", e.name, a, e.exp, $time);
      end
    end
  end
  task automatic chk(string n, int s, logic [31:0] e);
    q.push_back('{n, s, e});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load_word(logic [31:0] d, logic last);
    load_valid = 1; load_data = d; load_last = last;
    tick();
    load_valid = 0; load_last = 0;
  endtask
  task automatic probe(string n, logic [31:0] addr, logic [31:0] e);
    instr_address = addr;
    chk(n, 0, e);
    tick();
  endtask
  initial begin
    tick(); tick();
    reset = 0;
    instr_address = 32'hBFC00000;
    chk("rst_mem_ready", 2, 0); chk("rst_load_ready", 3, 1); chk("rst_halted", 4, 0);
    chk("rst_fault_seen", 5, 0); chk("rst_overflow", 6, 0); chk("rst_count", 7, 0);
    chk("load_rd", 0, 0); chk("load_fault", 1, 0);
    tick();
    load_word(32'h11111111, 0); load_word(32'h22222222, 0); load_word(32'h33333333, 0);
    reset = 1; tick(); reset = 0;
    chk("midrst_mem_ready", 2, 0); chk("midrst_load_ready", 3, 1);
    load_word(32'hAAAA0001, 0); load_word(32'hAAAA0002, 1);
    chk("short_mem_ready", 2, 1);
    probe("short_w0", 32'hBFC00000, 32'hAAAA0001);
    probe("short_w1", 32'hBFC00004, 32'hAAAA0002);
    probe("short_w2_cleared", 32'hBFC00008, 32'h0);
    reload = 1; tick(); reload = 0;
    chk("reload_mem_ready", 2, 0); chk("reload_load_ready", 3, 1);
    for (int i = 0; i < 8; i++) load_word(prog[i], i == 7);
    chk("prog_mem_ready", 2, 1); chk("prog_load_ready", 3, 0);
    probe("prog_08", 32'hBFC00008, 32'h04300002);
    probe("prog_1c", 32'hBFC0001C, 32'h24000000);
    chk("pre_fault_seen", 5, 0); chk("idle_count", 7, 0);
    instr_address = 32'hBFC00100;
    chk("range_rd", 0, 0); chk("range_fault", 1, 1);
    tick();
    chk("range_fault_seen", 5, 1);
    instr_address = 32'hBFC00006;
    chk("misalign_rd", 0, 0); chk("misalign_fault", 1, 1); chk("no_halt_yet", 4, 0);
    tick();
    clk_enable = 1;
    for (int i = 0; i < 5; i++) begin
      instr_address = 32'hBFC00000 + 32'(i * 4);
      chk("run_rd", 0, prog[i]); chk("run_fault", 1, 0);
      tick();
    end
    clk_enable = 0;
    tick(); tick(); tick();
    chk("frozen_count", 7, 5);
    clk_enable = 1; instr_address = 32'h0;
    chk("halt_rd", 0, 0); chk("halt_fault", 1, 0);
    tick();
    chk("halted", 4, 1); chk("halt_count", 7, 5); chk("fault_sticky", 5, 1);
    clk_enable = 0; instr_address = 32'hBFC00010; reload = 1;
    tick();
    reload = 0;
    chk("rl_halted", 4, 0); chk("rl_count", 7, 0); chk("rl_fault_seen", 5, 0);
    chk("rl_mem_ready", 2, 0); chk("rl_overflow", 6, 0); chk("rl_load_rd", 0, 0);
    load_word(32'hDEADBEEF, 1);
    probe("rl_w0_new", 32'hBFC00000, 32'hDEADBEEF);
    probe("rl_w1_kept", 32'hBFC00004, 32'h00010823);
    load_valid = 1; load_data = 32'h12345678;
    chk("serve_load_ready", 3, 0);
    tick();
    load_valid = 0;
    probe("serve_ignore_load", 32'hBFC00000, 32'hDEADBEEF);
    b_load_valid = 1;
    for (int i = 0; i < 4; i++) begin
      b_load_data = 32'hB0 + 32'(i);
      chk("b_load_ready", 10, 1);
      tick();
    end
    b_load_data = 32'hB4;
    chk("b_mem_ready", 8, 1); chk("b_overflow", 9, 1); chk("b_fifth_ready", 10, 0);
    tick();
    b_load_valid = 0;
    chk("b_w0_kept", 11, 32'hB0); chk("overflow_a_clear", 6, 0);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
